// File: rtl/mem_router_pkg.sv
// Shared types for the Avalon-MM memory router: tracker state encoding and address window decode.
// Decode is purely combinational; the window test is shared by the router top.
package mem_router_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_PEND  = 2'd1,
        WR_BURST = 2'd2
    } state_e;

    // Widest supported word address; narrower addresses are zero-extended.
    localparam int DEC_W = 64;

    function automatic logic ch_decode(input logic [DEC_W-1:0] addr,
                                       input logic [DEC_W-1:0] base,
                                       input logic [DEC_W-1:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/mem_router_track.sv
// Transaction tracker: outstanding read beats/owner channel and the active write burst channel.
// State updates one cycle after an accept or beat; it never stalls by itself.
module mem_router_track
    import mem_router_pkg::*;
#(
    parameter int CHW     = 1,
    parameter int CW      = 4,
    parameter int BURST_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CHW-1:0]     sel_i,
    input  logic               rd_acc_i,
    input  logic               wr_acc_i,
    input  logic [BURST_W-1:0] bc_i,
    input  logic               beat_i,
    output logic               wr_burst_o,
    output logic [CW-1:0]      rd_cnt_o,
    output logic [CHW-1:0]     rd_ch_o,
    output logic [CHW-1:0]     wr_ch_o
);

    state_e             state_q, state_d;
    logic [CW-1:0]      rd_cnt_q, rd_cnt_d;
    logic [BURST_W-1:0] wr_left_q, wr_left_d;
    logic [CHW-1:0]     rd_ch_q, rd_ch_d;
    logic [CHW-1:0]     wr_ch_q, wr_ch_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            wr_left_q <= '0;
            rd_ch_q   <= '0;
            wr_ch_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_left_q <= wr_left_d;
            rd_ch_q   <= rd_ch_d;
            wr_ch_q   <= wr_ch_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        wr_left_d = wr_left_q;
        rd_ch_d   = rd_ch_q;
        wr_ch_d   = wr_ch_q;
        if (rd_acc_i) begin
            rd_ch_d  = sel_i;
            rd_cnt_d = rd_cnt_q + CW'(bc_i);
        end
        if (beat_i) begin
            rd_cnt_d = rd_cnt_d - CW'(1);
        end
        case (state_q)
            IDLE, RD_PEND: begin
                if (wr_acc_i && bc_i > BURST_W'(1)) begin
                    state_d   = WR_BURST;
                    wr_left_d = bc_i - BURST_W'(1);
                    wr_ch_d   = sel_i;
                end else begin
                    state_d = (rd_cnt_d != '0) ? RD_PEND : IDLE;
                end
            end
            WR_BURST: begin
                if (wr_acc_i) begin
                    wr_left_d = wr_left_q - BURST_W'(1);
                    if (wr_left_q == BURST_W'(1)) begin
                        state_d = (rd_cnt_d != '0) ? RD_PEND : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_burst_o = (state_q == WR_BURST);
        rd_cnt_o   = rd_cnt_q;
        rd_ch_o    = rd_ch_q;
        wr_ch_o    = wr_ch_q;
    end

endmodule

// File: rtl/avalon_mem_router.sv
// N-channel Avalon-MM router: window decode, zero-latency command/response muxing, in-order reads.
// Stalls via s_waitrequest on channel switch with reads pending or read-beat overflow; MEM_ROUTER_PERF_EN adds counters.
module avalon_mem_router
    import mem_router_pkg::*;
#(
    parameter int                        NUM_CH     = 2,
    parameter int                        ADDR_W     = 30,
    parameter int                        DATA_W     = 32,
    parameter int                        BURST_W    = 3,
    parameter int                        MAX_OUTST  = 8,
    parameter logic [NUM_CH*ADDR_W-1:0]  CH_BASE    = '0,
    parameter logic [NUM_CH*ADDR_W-1:0]  CH_MASK    = '0,
    parameter int                        DEFAULT_CH = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            s_address,
    input  logic [DATA_W/8-1:0]          s_byteenable,
    input  logic                         s_read,
    input  logic                         s_write,
    input  logic [DATA_W-1:0]            s_writedata,
    input  logic [BURST_W-1:0]           s_burstcount,
    output logic                         s_waitrequest,
    output logic [DATA_W-1:0]            s_readdata,
    output logic                         s_readdatavalid,
    output logic [NUM_CH*ADDR_W-1:0]     m_address,
    output logic [NUM_CH*DATA_W/8-1:0]   m_byteenable,
    output logic [NUM_CH-1:0]            m_read,
    output logic [NUM_CH-1:0]            m_write,
    output logic [NUM_CH*DATA_W-1:0]     m_writedata,
    output logic [NUM_CH*BURST_W-1:0]    m_burstcount,
    input  logic [NUM_CH-1:0]            m_waitrequest,
    input  logic [NUM_CH*DATA_W-1:0]     m_readdata,
    input  logic [NUM_CH-1:0]            m_readdatavalid,
    output logic                         err_spurious,
    output logic [NUM_CH*32-1:0]         perf_cmd_cnt,
    output logic [31:0]                  perf_stall_cnt
);

    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW  = $clog2(MAX_OUTST + 1);

    logic [CHW-1:0]     dec_sel, sel, rd_ch, wr_ch;
    logic [CW-1:0]      rd_cnt;
    logic [BURST_W-1:0] bc;
    logic               wr_burst, rd_busy, stall, rd_acc, wr_acc, beat, spurious;
    logic [NUM_CH-1:0]  own_mask;
    logic               err_spurious_q;

    // Descending scan so the lowest matching window wins.
    always_comb begin
        dec_sel = CHW'(DEFAULT_CH);
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_decode(DEC_W'(s_address),
                          DEC_W'(CH_BASE[i*ADDR_W +: ADDR_W]),
                          DEC_W'(CH_MASK[i*ADDR_W +: ADDR_W]))) begin
                dec_sel = CHW'(i);
            end
        end
    end

    assign sel     = wr_burst ? wr_ch : dec_sel;
    assign bc      = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
    assign rd_busy = (rd_cnt != '0);

    assign stall = (rd_busy && sel != rd_ch)
                 || (s_read && (32'(rd_cnt) + 32'(bc) > 32'(MAX_OUTST)))
                 || (s_read && wr_burst);

    assign s_waitrequest = stall | m_waitrequest[sel];
    assign rd_acc        = s_read  && !s_waitrequest;
    assign wr_acc        = s_write && !s_waitrequest;

    assign m_address    = {NUM_CH{s_address}};
    assign m_byteenable = {NUM_CH{s_byteenable}};
    assign m_writedata  = {NUM_CH{s_writedata}};
    assign m_burstcount = {NUM_CH{s_burstcount}};

    always_comb begin
        m_read  = '0;
        m_write = '0;
        if (!stall) begin
            m_read[sel]  = s_read;
            m_write[sel] = s_write;
        end
    end

    assign beat            = m_readdatavalid[rd_ch] && rd_busy;
    assign s_readdatavalid = beat;
    assign s_readdata      = m_readdata[int'(rd_ch)*DATA_W +: DATA_W];
    assign own_mask        = rd_busy ? (NUM_CH'(1) << rd_ch) : '0;
    assign spurious        = |(m_readdatavalid & ~own_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_spurious_q <= 1'b0;
        end else if (spurious) begin
            err_spurious_q <= 1'b1;
        end
    end
    assign err_spurious = err_spurious_q;

    mem_router_track #(
        .CHW     (CHW),
        .CW      (CW),
        .BURST_W (BURST_W)
    ) u_track (
        .clk        (clk),
        .rst        (rst),
        .sel_i      (sel),
        .rd_acc_i   (rd_acc),
        .wr_acc_i   (wr_acc),
        .bc_i       (bc),
        .beat_i     (beat),
        .wr_burst_o (wr_burst),
        .rd_cnt_o   (rd_cnt),
        .rd_ch_o    (rd_ch),
        .wr_ch_o    (wr_ch)
    );

`ifdef MEM_ROUTER_PERF_EN
    logic [NUM_CH*32-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [31:0]          stall_cnt_q, stall_cnt_d;

    // Continuation beats of a write burst are not new commands.
    always_comb begin
        cmd_cnt_d = cmd_cnt_q;
        if ((rd_acc || wr_acc) && !wr_burst) begin
            cmd_cnt_d[int'(sel)*32 +: 32] = cmd_cnt_q[int'(sel)*32 +: 32] + 32'd1;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (s_read || s_write)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            cmd_cnt_q   <= cmd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_cmd_cnt   = cmd_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_cmd_cnt   = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_avalon_mem_router.sv
// Bench for avalon_mem_router: directed scenarios then randomized traffic against a transaction-level model.
module tb_avalon_mem_router;

    localparam int NUM_CH = 2, ADDR_W = 30, DATA_W = 32, BURST_W = 3, MAX_OUTST = 8, DEF_CH = 0;
    localparam logic [ADDR_W-1:0] W_BASE [NUM_CH] = '{30'h00000, 30'h28000};
    localparam logic [ADDR_W-1:0] W_MASK [NUM_CH] = '{30'h20000, 30'h3F000};

    logic                        clk = 1'b0;
    logic                        rst;
    logic [ADDR_W-1:0]           s_address;
    logic [DATA_W/8-1:0]         s_byteenable;
    logic                        s_read, s_write;
    logic [DATA_W-1:0]           s_writedata;
    logic [BURST_W-1:0]          s_burstcount;
    logic                        s_waitrequest;
    logic [DATA_W-1:0]           s_readdata;
    logic                        s_readdatavalid;
    logic [NUM_CH*ADDR_W-1:0]    m_address;
    logic [NUM_CH*DATA_W/8-1:0]  m_byteenable;
    logic [NUM_CH-1:0]           m_read, m_write;
    logic [NUM_CH*DATA_W-1:0]    m_writedata;
    logic [NUM_CH*BURST_W-1:0]   m_burstcount;
    logic [NUM_CH-1:0]           m_waitrequest;
    logic [NUM_CH*DATA_W-1:0]    m_readdata;
    logic [NUM_CH-1:0]           m_readdatavalid;
    logic                        err_spurious;
    logic [NUM_CH*32-1:0]        perf_cmd_cnt;
    logic [31:0]                 perf_stall_cnt;

    avalon_mem_router #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
        .MAX_OUTST(MAX_OUTST),
        .CH_BASE({W_BASE[1], W_BASE[0]}), .CH_MASK({W_MASK[1], W_MASK[0]}),
        .DEFAULT_CH(DEF_CH)
    ) dut (
        .clk(clk), .rst(rst),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_burstcount(s_burstcount), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .m_address(m_address), .m_byteenable(m_byteenable), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_burstcount(m_burstcount), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .err_spurious(err_spurious), .perf_cmd_cnt(perf_cmd_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [BURST_W-1:0] bc;
        logic [3:0]        be;
        logic [31:0]       wd;
    } cmd_t;

    int n_vec = 0, n_bad = 0;

    cmd_t        cmd_q[$];
    cmd_t        cur;
    logic        cur_vld = 1'b0;
    logic [31:0] slv_q [NUM_CH][$];
    int          resp_pct [NUM_CH];
    int          wait_pct [NUM_CH];
    int          inj_ch = -1;

    // Reference model state (transaction level).
    logic [31:0] exp_q[$];
    int          out_cnt = 0, out_ch = 0, wr_left = 0, wr_ch = 0;
    logic        err_m = 1'b0;
    int          tot_req = 0, tot_got = 0;
    int          pc_cmd [NUM_CH];
    int          pc_stall = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_sel(input logic [ADDR_W-1:0] a);
        for (int i = 0; i < NUM_CH; i++)
            if ((a & W_MASK[i]) == W_BASE[i]) return i;
        return DEF_CH;
    endfunction

    function automatic int bc_eff(input logic [BURST_W-1:0] b);
        return (b == '0) ? 1 : int'(b);
    endfunction

    // Slave read data tags the serving channel and beat address.
    function automatic logic [31:0] slv_data(input int ch, input logic [ADDR_W-1:0] a, input int k);
        logic [1:0] c2;
        c2 = 2'(ch);
        return {c2, 30'(a + 30'(k))};
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 2) == 0) return 30'h28000 | 30'($urandom_range(0, 4095));
        return 30'($urandom);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        out_cnt = 0; out_ch = 0; wr_left = 0; wr_ch = 0;
        err_m = 1'b0; tot_req = 0; tot_got = 0; pc_stall = 0;
        for (int c = 0; c < NUM_CH; c++) pc_cmd[c] = 0;
    endtask

    task automatic step();
        int          sel, own, bcv;
        logic        stall, exp_wait, exp_v, spur, acc;
        logic [NUM_CH-1:0] exp_rd, exp_wr;
        logic [31:0] exp_d;
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            m_readdatavalid[c] = 1'b0;
            m_readdata[c*DATA_W +: DATA_W] = $urandom;
            if (slv_q[c].size() > 0 && int'($urandom_range(0, 99)) < resp_pct[c]) begin
                m_readdatavalid[c] = 1'b1;
                m_readdata[c*DATA_W +: DATA_W] = slv_q[c].pop_front();
            end
            if (inj_ch == c) m_readdatavalid[c] = 1'b1;
            m_waitrequest[c] = int'($urandom_range(0, 99)) < wait_pct[c];
        end
        inj_ch = -1;
        if (!rst && !cur_vld && cmd_q.size() > 0) begin
            cur = cmd_q.pop_front();
            cur_vld = 1'b1;
        end
        s_read       = cur_vld && cur.rd;
        s_write      = cur_vld && cur.wr;
        s_address    = cur_vld ? cur.addr : '0;
        s_burstcount = cur_vld ? cur.bc : '0;
        s_byteenable = cur_vld ? cur.be : '0;
        s_writedata  = cur_vld ? cur.wd : '0;
        @(negedge clk);
        if (rst) begin
            check_val("rst_rdvalid", s_readdatavalid, 0);
            check_val("rst_err", err_spurious, 0);
            check_val("rst_perf_stall", perf_stall_cnt, 0);
            check_val("rst_perf_cmd", perf_cmd_cnt, 0);
            check_val("rst_waitreq", s_waitrequest, m_waitrequest[DEF_CH]);
            model_reset();
            cur_vld = 1'b0;
            return;
        end
        bcv   = bc_eff(s_burstcount);
        sel   = (wr_left > 0) ? wr_ch : ref_sel(s_address);
        stall = (out_cnt > 0 && sel != out_ch) || (s_read && (out_cnt + bcv > MAX_OUTST))
              || (s_read && wr_left > 0);
        exp_wait = stall || m_waitrequest[sel];
        exp_rd = (s_read  && !stall) ? (NUM_CH'(1) << sel) : '0;
        exp_wr = (s_write && !stall) ? (NUM_CH'(1) << sel) : '0;
        check_val("s_waitrequest", s_waitrequest, exp_wait);
        check_val("m_read", m_read, exp_rd);
        check_val("m_write", m_write, exp_wr);

        own   = (out_cnt > 0) ? out_ch : -1;
        exp_v = (own >= 0) && m_readdatavalid[own];
        check_val("s_readdatavalid", s_readdatavalid, exp_v);
        if (s_readdatavalid) tot_got++;
        if (exp_v) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check_val("s_readdata", s_readdata, exp_d);
        end
        spur = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            if (m_readdatavalid[c] && c != own) spur = 1'b1;
        check_val("err_spurious", err_spurious, err_m);

        acc = (s_read || s_write) && !s_waitrequest;
        if (stall && (s_read || s_write)) pc_stall++;
        if (exp_v) out_cnt--;
        if (acc) begin
            if (wr_left == 0) pc_cmd[sel]++;
            if (s_read) begin
                out_ch = sel;
                out_cnt += bcv;
                tot_req += bcv;
                for (int k = 0; k < bcv; k++) exp_q.push_back(slv_data(sel, s_address, k));
            end else begin
                check_val("m_address", m_address[sel*ADDR_W +: ADDR_W], s_address);
                check_val("m_writedata", m_writedata[sel*DATA_W +: DATA_W], s_writedata);
                check_val("m_byteenable", m_byteenable[sel*4 +: 4], s_byteenable);
                if (wr_left > 0) wr_left--;
                else if (bcv > 1) begin
                    wr_left = bcv - 1;
                    wr_ch   = sel;
                end
            end
            cur_vld = 1'b0;
        end
        if (cur_vld && !cur.rd && !cur.wr) cur_vld = 1'b0;
        err_m = err_m | spur;

        for (int c = 0; c < NUM_CH; c++) begin
            if (m_read[c] && !m_waitrequest[c]) begin
                for (int k = 0; k < bc_eff(m_burstcount[c*BURST_W +: BURST_W]); k++)
                    slv_q[c].push_back(slv_data(c, m_address[c*ADDR_W +: ADDR_W], k));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int left;
        for (int i = 0; i < budget; i++) begin
            if (cmd_q.size() == 0 && !cur_vld && out_cnt == 0 &&
                slv_q[0].size() == 0 && slv_q[1].size() == 0) break;
            step();
        end
        left = cmd_q.size() + int'(cur_vld) + out_cnt + slv_q[0].size() + slv_q[1].size();
        check_val("drain_left", left, 0);
        check_val("beats_total", tot_got, tot_req);
    endtask

    task automatic push_cmd(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [BURST_W-1:0] b);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = a; c.bc = b;
        c.be = 4'($urandom); c.wd = $urandom;
        cmd_q.push_back(c);
    endtask

    task automatic wait_issued(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (cmd_q.size() == 0 && !cur_vld) break;
            step();
        end
        check_val("issue_left", cmd_q.size() + int'(cur_vld), 0);
    endtask

    initial begin
        logic [63:0] e_stall, e_cmd0, e_cmd1;
        rst = 1'b1;
        s_read = 0; s_write = 0; s_address = '0; s_burstcount = '0;
        s_byteenable = '0; s_writedata = '0;
        m_waitrequest = '0; m_readdata = '0; m_readdatavalid = '0;
        for (int c = 0; c < NUM_CH; c++) begin resp_pct[c] = 100; wait_pct[c] = 0; end
        model_reset();
        do_reset();

        // Window decode and data return.
        push_cmd(1, 0, 30'h28010, 3'd1);
        push_cmd(1, 0, 30'h00010, 3'd1);
        push_cmd(1, 0, 30'h30010, 3'd2);
        drain(200);

        // Channel switch stalls until all ch0 beats are back.
        resp_pct[0] = 40;
        push_cmd(1, 0, 30'h00100, 3'd4);
        push_cmd(1, 0, 30'h28020, 3'd1);
        drain(400);
        resp_pct[0] = 100;

        // Write burst sticks to the first beat's channel.
        push_cmd(0, 1, 30'h28004, 3'd4);
        push_cmd(0, 1, 30'h00010, 3'd0);
        push_cmd(0, 1, 30'h00011, 3'd3);
        push_cmd(0, 1, 30'h00012, 3'd1);
        push_cmd(1, 0, 30'h00020, 3'd1);
        drain(200);

        // Read accepted in the same cycle a prior beat returns.
        resp_pct[0] = 0;
        push_cmd(1, 0, 30'h00200, 3'd1);
        wait_issued(50);
        push_cmd(1, 0, 30'h00210, 3'd2);
        resp_pct[0] = 100;
        drain(200);

        // Spurious beat while idle: dropped and sticky.
        inj_ch = 1;
        for (int i = 0; i < 4; i++) step();

        // Reset with reads in flight; the late beats become spurious.
        do_reset();
        resp_pct[0] = 0;
        push_cmd(1, 0, 30'h00300, 3'd3);
        wait_issued(50);
        step();
        do_reset();
        resp_pct[0] = 100;
        drain(100);
        push_cmd(1, 0, 30'h28030, 3'd2);
        drain(200);

        do_reset();
        for (int blk = 0; blk < 10; blk++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                resp_pct[c] = $urandom_range(30, 100);
                wait_pct[c] = $urandom_range(0, 40);
            end
            for (int n = 0; n < 25; n++) begin
                int kind;
                logic [BURST_W-1:0] b;
                kind = $urandom_range(0, 9);
                b = 3'($urandom_range(0, 7));
                if (kind < 2) push_cmd(0, 0, rand_addr(), b);
                else if (kind < 6) push_cmd(1, 0, rand_addr(), b);
                else begin
                    push_cmd(0, 1, rand_addr(), b);
                    for (int k = 1; k < bc_eff(b); k++) push_cmd(0, 1, rand_addr(), 3'($urandom));
                end
            end
            drain(4000);
        end

        e_stall = 0; e_cmd0 = 0; e_cmd1 = 0;
`ifdef MEM_ROUTER_PERF_EN
        e_stall = 64'(pc_stall); e_cmd0 = 64'(pc_cmd[0]); e_cmd1 = 64'(pc_cmd[1]);
`endif
        check_val("perf_stall_cnt", perf_stall_cnt, e_stall);
        check_val("perf_cmd_cnt0", perf_cmd_cnt[31:0], e_cmd0);
        check_val("perf_cmd_cnt1", perf_cmd_cnt[63:32], e_cmd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
